// File: rtl/comms_pkg.sv
// Shared definitions for the serial receive path: receive-frame FSM state
// encoding and default link constants.
package comms_pkg;

   // Frame sub-FSM states of the receiver.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

   localparam int CLK_BAUD_RATIO_DEFAULT = 25;
   localparam int FRAME_SIZE_DEFAULT     = 8;

endpackage : comms_pkg

// File: rtl/recv_frame_rx.sv
// Single-frame receiver: two-flop synchroniser on the serial line, start-edge
// detection, a bit timer and the IDLE/START/DATA/STOP frame FSM. Emits a
// one-cycle frame_done or frame_err strobe in the stop-sample cycle, with the
// received bits (LSB first on the line) presented on frame_data.
module recv_frame_rx
   import comms_pkg::*;
#(
   parameter int CLK_BAUD_RATIO = CLK_BAUD_RATIO_DEFAULT,
   parameter int FRAME_SIZE     = FRAME_SIZE_DEFAULT
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  rx_in,
   output logic                  frame_done,
   output logic                  frame_err,
   output logic [FRAME_SIZE-1:0] frame_data,
   output logic                  rx_busy
);

   localparam int TW = $clog2(CLK_BAUD_RATIO);
   localparam int BW = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
   localparam logic [TW-1:0] HALF_C     = TW'(CLK_BAUD_RATIO / 2);
   localparam logic [TW-1:0] FULL_C     = TW'(CLK_BAUD_RATIO - 1);
   localparam logic [BW-1:0] LAST_BIT_C = BW'(FRAME_SIZE - 1);

   logic                  sync1_q, sync1_d;
   logic                  sync2_q, sync2_d;
   logic                  prev_q, prev_d;
   rx_state_e             state_q, state_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [FRAME_SIZE-1:0] shift_q, shift_d;
   logic                  rxs_s;
   logic                  start_edge_s;
   logic                  done_s;
   logic                  err_s;

   assign rxs_s        = sync2_q;
   assign start_edge_s = prev_q & ~sync2_q;

   // Synchroniser chain plus one delayed copy for falling-edge detection.
   always_comb begin
      sync1_d = rx_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   // Frame FSM: start validation at mid-bit, data sampling, stop check.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      done_s    = 1'b0;
      err_s     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_edge_s) begin
               state_d = START;
               timer_d = {TW{1'b0}};
            end else begin
               timer_d = {TW{1'b0}};
            end
         end
         START: begin
            if (timer_q == HALF_C) begin
               timer_d   = {TW{1'b0}};
               bit_cnt_d = {BW{1'b0}};
               if (!rxs_s) begin
                  state_d = DATA;
               end else begin
                  // Line back high at mid-start: glitch, drop silently.
                  state_d = IDLE;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         DATA: begin
            if (timer_q == FULL_C) begin
               timer_d = {TW{1'b0}};
               shift_d = (shift_q >> 1) | (FRAME_SIZE'(rxs_s) << (FRAME_SIZE - 1));
               if (bit_cnt_q == LAST_BIT_C) begin
                  state_d = STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         STOP: begin
            if (timer_q == FULL_C) begin
               timer_d = {TW{1'b0}};
               state_d = IDLE;
               done_s  = rxs_s;
               err_s   = ~rxs_s;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = {TW{1'b0}};
         end
      endcase
   end

   // State registers; synchroniser resets to the idle-high line level.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         prev_q    <= 1'b1;
         state_q   <= IDLE;
         timer_q   <= {TW{1'b0}};
         bit_cnt_q <= {BW{1'b0}};
         shift_q   <= {FRAME_SIZE{1'b0}};
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         prev_q    <= prev_d;
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
      end
   end

   assign frame_done = done_s;
   assign frame_err  = err_s;
   assign frame_data = shift_q;
   assign rx_busy    = (state_q != IDLE);

endmodule : recv_frame_rx

// File: rtl/recv_frames.sv
// Multi-frame UART receiver: assembles FRAMES consecutive frames (first frame
// in the least-significant bits) into one word, strobing valid_out when the
// word completes and error_out on a framing error.
// Optional feature: define RECV_FRAMES_TIMEOUT_EN to abort a partial word that
// sits idle for TIMEOUT_BITS bit-times; without it a partial word waits forever.
module recv_frames
   import comms_pkg::*;
#(
   parameter  int CLK_BAUD_RATIO = CLK_BAUD_RATIO_DEFAULT,
   parameter  int FRAME_SIZE     = FRAME_SIZE_DEFAULT,
   parameter  int FRAMES         = 2,
   parameter  int TIMEOUT_BITS   = 16,
   localparam int DATA_SIZE      = FRAME_SIZE * FRAMES
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 rx_in,
   output logic [DATA_SIZE-1:0] data_out,
   output logic                 valid_out,
   output logic                 error_out,
   output logic                 busy_out
);

   localparam int CNT_W = $clog2(FRAMES + 1);
   localparam logic [CNT_W-1:0]     LAST_FRAME_C = CNT_W'(FRAMES - 1);
   localparam logic [DATA_SIZE-1:0] FRAME_MASK_C = DATA_SIZE'({FRAME_SIZE{1'b1}});

   // Reject parameter sets the bit timer cannot support.
   if (CLK_BAUD_RATIO < 4 || TIMEOUT_BITS < 1) begin : g_bad_param
      $error("recv_frames: CLK_BAUD_RATIO must be >= 4 and TIMEOUT_BITS >= 1");
   end

   logic                  frame_done_s;
   logic                  frame_err_s;
   logic [FRAME_SIZE-1:0] frame_data_s;
   logic                  rx_busy_s;
   logic                  timeout_s;
   logic [DATA_SIZE-1:0]  word_s;
   int                    shamt_s;

   logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
   logic [DATA_SIZE-1:0]  asm_q, asm_d;
   logic [DATA_SIZE-1:0]  data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  error_q, error_d;

   recv_frame_rx #(
      .CLK_BAUD_RATIO (CLK_BAUD_RATIO),
      .FRAME_SIZE     (FRAME_SIZE)
   ) u_rx (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .rx_in      (rx_in),
      .frame_done (frame_done_s),
      .frame_err  (frame_err_s),
      .frame_data (frame_data_s),
      .rx_busy    (rx_busy_s)
   );

`ifdef RECV_FRAMES_TIMEOUT_EN
   localparam int TO_LIMIT = TIMEOUT_BITS * CLK_BAUD_RATIO;
   localparam int TO_W     = $clog2(TO_LIMIT + 1);
   localparam logic [TO_W-1:0] TO_LAST_C = TO_W'(TO_LIMIT - 1);

   logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;

   // Idle counter runs only between frames of a partial word; any activity
   // on the frame FSM (including a false start) clears it.
   always_comb begin
      timeout_s  = 1'b0;
      idle_cnt_d = {TO_W{1'b0}};
      if (!rx_busy_s && (frame_cnt_q != {CNT_W{1'b0}})) begin
         if (idle_cnt_q == TO_LAST_C) begin
            timeout_s = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + TO_W'(1);
         end
      end else begin
         idle_cnt_d = {TO_W{1'b0}};
      end
   end

   // Idle counter register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         idle_cnt_q <= {TO_W{1'b0}};
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`else
   // No timeout: a partial word is held until its remaining frames arrive.
   always_comb begin
      timeout_s = 1'b0;
   end
`endif

   // Word assembly: place the frame at its slot, publish on the last frame,
   // discard the partial word on framing error or timeout.
   always_comb begin
      shamt_s     = int'(frame_cnt_q) * FRAME_SIZE;
      word_s      = (asm_q & ~(FRAME_MASK_C << shamt_s)) |
                    (DATA_SIZE'(frame_data_s) << shamt_s);
      frame_cnt_d = frame_cnt_q;
      asm_d       = asm_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      error_d     = 1'b0;
      if (frame_err_s) begin
         error_d     = 1'b1;
         frame_cnt_d = {CNT_W{1'b0}};
         asm_d       = {DATA_SIZE{1'b0}};
      end else if (frame_done_s) begin
         if (frame_cnt_q == LAST_FRAME_C) begin
            data_d      = word_s;
            valid_d     = 1'b1;
            frame_cnt_d = {CNT_W{1'b0}};
            asm_d       = {DATA_SIZE{1'b0}};
         end else begin
            asm_d       = word_s;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
         end
      end else if (timeout_s) begin
         error_d     = 1'b1;
         frame_cnt_d = {CNT_W{1'b0}};
         asm_d       = {DATA_SIZE{1'b0}};
      end else begin
         asm_d = asm_q;
      end
   end

   // Word-level registers and registered strobes.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         frame_cnt_q <= {CNT_W{1'b0}};
         asm_q       <= {DATA_SIZE{1'b0}};
         data_q      <= {DATA_SIZE{1'b0}};
         valid_q     <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         asm_q       <= asm_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         error_q     <= error_d;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign error_out = error_q;
   assign busy_out  = rx_busy_s | (frame_cnt_q != {CNT_W{1'b0}});

endmodule : recv_frames

// File: tb/tb_recv_frames.sv
// Self-checking bench for recv_frames: directed scenarios plus a random frame
// stream, checked against a word-level model of the frames sent.
module tb_recv_frames;

   localparam int CBR = 25;
   localparam int FS  = 8;
   localparam int FR  = 2;
   localparam int TB  = 16;
   localparam int DS  = FS * FR;
`ifdef RECV_FRAMES_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          rx    = 1'b1;
   logic [DS-1:0] data_out;
   logic          valid_out;
   logic          error_out;
   logic          busy_out;

   always #5 clk = ~clk;

   recv_frames #(
      .CLK_BAUD_RATIO (CBR),
      .FRAME_SIZE     (FS),
      .FRAMES         (FR),
      .TIMEOUT_BITS   (TB)
   ) dut (
      .clk_in    (clk),
      .rst_n_in  (rst_n),
      .rx_in     (rx),
      .data_out  (data_out),
      .valid_out (valid_out),
      .error_out (error_out),
      .busy_out  (busy_out)
   );

   int            n_chk      = 0;
   int            n_fail     = 0;
   int            err_seen   = 0;
   int            exp_err    = 0;
   int            valid_seen = 0;
   logic [DS-1:0] exp_q[$];
   logic [DS-1:0] model_last = '0;
   logic [DS-1:0] m_asm      = '0;
   int            m_cnt      = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Model: a frame either extends the partial word or kills it.
   task automatic model_frame(input logic [FS-1:0] b, input bit ok);
      if (!ok) begin
         exp_err++;
         m_cnt = 0;
         m_asm = '0;
      end else begin
         m_asm = m_asm | (DS'(b) << (FS * m_cnt));
         m_cnt++;
         if (m_cnt == FR) begin
            exp_q.push_back(m_asm);
            m_cnt = 0;
            m_asm = '0;
         end
      end
   endtask

   task automatic send_frame(input logic [FS-1:0] b, input bit ok);
      model_frame(b, ok);
      rx = 1'b0;
      tick(CBR);
      for (int i = 0; i < FS; i++) begin
         rx = b[i];
         tick(CBR);
      end
      rx = ok;
      tick(CBR);
      rx = 1'b1;
      if (!ok) tick(CBR);
   endtask

   task automatic send_word(input logic [DS-1:0] w);
      for (int f = 0; f < FR; f++) send_frame(w[f*FS +: FS], 1'b1);
   endtask

   task automatic idle_bits(input int n);
      if (TO_EN && m_cnt != 0 && n > TB + 1) begin
         exp_err++;
         m_cnt = 0;
         m_asm = '0;
      end
      rx = 1'b1;
      tick(n * CBR);
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      rx    = 1'b1;
      chk("rst_pending_words", exp_q.size(), 0);
      exp_q.delete();
      m_cnt      = 0;
      m_asm      = '0;
      model_last = '0;
      #1;
      chk("rst_data", data_out, 0);
      chk("rst_valid", valid_out, 0);
      chk("rst_error", error_out, 0);
      chk("rst_busy", busy_out, 0);
      tick(cycles);
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic scenario_end(input string name);
      idle_bits(3);
      chk({name, "_pending"}, exp_q.size(), 0);
      chk({name, "_errors"}, err_seen, exp_err);
      chk({name, "_busy"}, busy_out, (m_cnt != 0) ? 1 : 0);
   endtask

   // Every-cycle compare of the strobes and held word against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("valid_and_error", valid_out & error_out, 0);
         if (valid_out) begin
            valid_seen++;
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", valid_out, 0);
            end else begin
               model_last = exp_q.pop_front();
               chk("word", data_out, model_last);
            end
         end else begin
            chk("held_data", data_out, model_last);
         end
         if (error_out) err_seen++;
      end
   end

   initial begin
      int v0;
      #1;
      do_reset(3);

      // Good word, LSB frame first.
      v0 = valid_seen;
      send_frame(8'h34, 1'b1);
      send_frame(8'h12, 1'b1);
      scenario_end("good");
      chk("good_literal", data_out, 16'h1234);
      chk("good_one_valid", valid_seen - v0, 1);
      chk("good_no_error", err_seen, 0);

      // Short glitch is a false start.
      v0 = valid_seen;
      rx = 1'b0;
      tick(5);
      rx = 1'b1;
      tick(2 * CBR);
      chk("glitch_busy", busy_out, 0);
      chk("glitch_no_valid", valid_seen - v0, 0);
      chk("glitch_no_error", err_seen, 0);
      send_word(16'hBEEF);
      scenario_end("glitch");
      chk("glitch_literal", data_out, 16'hBEEF);

      // Framing error then a full word.
      send_frame(8'hAA, 1'b0);
      idle_bits(1);
      chk("ferr_count", err_seen, 1);
      chk("ferr_data_held", data_out, 16'hBEEF);
      send_word(16'h5566);
      scenario_end("ferr");
      chk("ferr_literal", data_out, 16'h5566);

      // Reset during the second frame's data bits.
      send_frame(8'h11, 1'b1);
      rx = 1'b0;
      tick(CBR);
      rx = 1'b0;
      tick(CBR);
      rx = 1'b1;
      tick(2 * CBR);
      do_reset(3);
      idle_bits(2);
      send_word(16'h2233);
      scenario_end("rst_mid");
      chk("rst_mid_literal", data_out, 16'h2233);

      // Long idle between frames of one word.
      v0 = err_seen;
      send_frame(8'h77, 1'b1);
      idle_bits(20);
      send_frame(8'h99, 1'b1);
      send_frame(8'h88, 1'b1);
      scenario_end("timeout");
`ifdef RECV_FRAMES_TIMEOUT_EN
      chk("timeout_err", err_seen - v0, 1);
      chk("timeout_literal", data_out, 16'h8899);
`else
      chk("no_timeout_err", err_seen - v0, 0);
      chk("no_timeout_literal", data_out, 16'h9977);
      chk("no_timeout_busy", busy_out, 1);
`endif
      do_reset(3);

      // Back-to-back words with no idle gap.
      v0 = valid_seen;
      send_word(16'h0102);
      send_word(16'h0304);
      send_word(16'h0506);
      scenario_end("b2b");
      chk("b2b_valids", valid_seen - v0, 3);
      chk("b2b_literal", data_out, 16'h0506);

      // Random frames, occasional bad stop bits and short gaps.
      for (int i = 0; i < 30; i++) begin
         send_frame(FS'($urandom), $urandom_range(0, 9) != 0);
         if ($urandom_range(0, 2) == 0) idle_bits($urandom_range(1, 2));
      end
      scenario_end("random");
      do_reset(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_recv_frames
